// File: rtl/hilo_move_seq.sv
// hilo_move_seq: control sequencer for the HI/LO move instructions
// (MFHI, MFLO, MTHI, MTLO) and the MUL/DIV hand-off to an external
// multiply/divide unit. Fetch runs T0..T2, decode/execute runs T3 onward.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no instruction in flight, waiting for run
//   T0     | PC to MAR, PC+1 into Z
//   T1     | memory read into MDR (1+MEM_WAIT cycles), PC <- Z in first
//   T2     | MDR to IR
//   T3     | decode ir_op; move ops finish here, MUL/DIV latch Y
//   T4     | second operand out, single-cycle start to mul/div unit
//   MDWAIT | waiting for mdiv_done, bounded by MD_TIMEOUT cycles
//   T5     | Z low half into LO
//   T6     | Z high half into HI
//   HALT   | stopped (HALT opcode or error); only clear leaves
//
// ir_op is the opcode field of the IR register loaded in T2, so the T3
// decode depends only on registered values and the machine stays Moore.
module hilo_move_seq #(
    parameter int             OPW        = 5,
    parameter int             MEM_WAIT   = 1,
    parameter int             MD_TIMEOUT = 40,
    parameter logic [OPW-1:0] OP_MFHI    = OPW'(5'h18),
    parameter logic [OPW-1:0] OP_MFLO    = OPW'(5'h19),
    parameter logic [OPW-1:0] OP_MTHI    = OPW'(5'h1A),
    parameter logic [OPW-1:0] OP_MTLO    = OPW'(5'h1B),
    parameter logic [OPW-1:0] OP_MUL     = OPW'(5'h0E),
    parameter logic [OPW-1:0] OP_DIV     = OPW'(5'h0F),
    parameter logic [OPW-1:0] OP_HALT    = OPW'(5'h1F)
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic           run,
    input  logic [OPW-1:0] ir_op,
    input  logic           mdiv_done,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zhighin,
    output logic           Zlowin,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Gra,
    output logic           Grb,
    output logic           Rin,
    output logic           Rout,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           HIout,
    output logic           LOout,
    output logic           mdiv_start,
    output logic           busy,
    output logic [1:0]     err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_MDWAIT,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    // T1 counter spans 0..MEM_WAIT; MDWAIT counter spans 0..MD_TIMEOUT-1.
    localparam int T1W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam int MDW = $clog2(MD_TIMEOUT);

    localparam logic [T1W-1:0] T1_LAST = T1W'(MEM_WAIT);
    localparam logic [MDW-1:0] MD_LAST = MDW'(MD_TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t         state;
    state_t         state_nx;
    logic [T1W-1:0] t1_cnt;
    logic [MDW-1:0] md_cnt;
    logic [1:0]     err_nx;

    // State, wait counters and sticky error; clear wins over everything.
    // Counters only advance while their state is held, so they read zero
    // on every state entry.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state  <= S_IDLE;
            t1_cnt <= '0;
            md_cnt <= '0;
            err    <= ERR_NONE;
        end else begin
            state  <= state_nx;
            t1_cnt <= (state == S_T1 && state_nx == S_T1) ? t1_cnt + 1'b1 : '0;
            md_cnt <= (state == S_MDWAIT && state_nx == S_MDWAIT) ? md_cnt + 1'b1 : '0;
            err    <= err_nx;
        end
    end

    // Next-state, error update and Moore strobe decode.
    always_comb begin
        state_nx   = state;
        err_nx     = err;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zhighin    = 1'b0;
        Zlowin     = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        Yin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        mdiv_start = 1'b0;
        busy       = 1'b1;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_nx = S_T0;
            end

            S_T0: begin
                PCout    = 1'b1;
                MARin    = 1'b1;
                IncPC    = 1'b1;
                Zhighin  = 1'b1;
                Zlowin   = 1'b1;
                state_nx = S_T1;
            end

            S_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = (t1_cnt == '0);
                if (t1_cnt == T1_LAST) state_nx = S_T2;
            end

            S_T2: begin
                MDRout   = 1'b1;
                IRin     = 1'b1;
                state_nx = S_T3;
            end

            S_T3: begin
                case (ir_op)
                    OP_MFHI: begin
                        HIout    = 1'b1;
                        Gra      = 1'b1;
                        Rin      = 1'b1;
                        state_nx = run ? S_T0 : S_IDLE;
                    end
                    OP_MFLO: begin
                        LOout    = 1'b1;
                        Gra      = 1'b1;
                        Rin      = 1'b1;
                        state_nx = run ? S_T0 : S_IDLE;
                    end
                    OP_MTHI: begin
                        Gra      = 1'b1;
                        Rout     = 1'b1;
                        HIin     = 1'b1;
                        state_nx = run ? S_T0 : S_IDLE;
                    end
                    OP_MTLO: begin
                        Gra      = 1'b1;
                        Rout     = 1'b1;
                        LOin     = 1'b1;
                        state_nx = run ? S_T0 : S_IDLE;
                    end
                    OP_MUL, OP_DIV: begin
                        Gra      = 1'b1;
                        Rout     = 1'b1;
                        Yin      = 1'b1;
                        state_nx = S_T4;
                    end
                    OP_HALT: begin
                        state_nx = S_HALT;
                    end
                    default: begin
                        err_nx   = ERR_ILLEGAL;
                        state_nx = S_HALT;
                    end
                endcase
            end

            S_T4: begin
                Grb        = 1'b1;
                Rout       = 1'b1;
                mdiv_start = 1'b1;
                state_nx   = S_MDWAIT;
            end

            // A done arriving on the last allowed cycle still counts.
            S_MDWAIT: begin
                if (mdiv_done) begin
                    state_nx = S_T5;
                end else if (md_cnt == MD_LAST) begin
                    err_nx   = ERR_TIMEOUT;
                    state_nx = S_HALT;
                end
            end

            S_T5: begin
                Zlowout  = 1'b1;
                LOin     = 1'b1;
                state_nx = S_T6;
            end

            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_nx = run ? S_T0 : S_IDLE;
            end

            S_HALT: begin
                busy = 1'b0;
            end

            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/hilo_move_seq.md
HILO_MOVE_SEQ -- requirements
Module: hilo_move_seq

Interface
REQ-001 Parameter OPW, default 5: opcode field width.
REQ-002 Parameter MEM_WAIT, default 1: extra T1 cycles for the memory read (0..15).
REQ-003 Parameter MD_TIMEOUT, default 40: maximum MDWAIT cycles before error (2..255).
REQ-004 Parameters OP_MFHI=5'h18, OP_MFLO=5'h19, OP_MTHI=5'h1A, OP_MTLO=5'h1B, OP_MUL=5'h0E, OP_DIV=5'h0F, OP_HALT=5'h1F: opcode encodings, each OPW wide.
REQ-005 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 clear  in  1  reset, synchronous and active-low.
REQ-007 run  in  1  level; high permits instruction fetch.
REQ-008 ir_op  in  OPW  opcode field of IR, valid from the cycle after IRin.
REQ-009 mdiv_done  in  1  multiply/divide unit result-ready pulse.
REQ-010 PCout, MARin, IncPC, Zhighin, Zlowin, Zhighout, Zlowout, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch-path datapath strobes.
REQ-011 Gra, Grb, Rin, Rout, Yin, HIin, LOin, HIout, LOout  out  1 each  execute-path strobes.
REQ-012 mdiv_start  out  1  single-cycle start to the mul/div unit.
REQ-013 busy  out  1  high in every state except IDLE and HALT.
REQ-014 err  out  2  sticky error code: 00 none, 01 illegal opcode, 10 mul/div timeout.

Function
REQ-015 The module SHALL be a Moore FSM; all outputs SHALL decode from the state register and counters only.
REQ-016 States SHALL be IDLE, T0, T1, T2, T3, T4, MDWAIT, T5, T6, HALT.
REQ-017 IDLE: all strobes low; go to T0 when run=1, otherwise remain.
REQ-018 T0 (1 cycle): PCout, MARin, IncPC, Zhighin, Zlowin high; go to T1.
REQ-019 T1 (1+MEM_WAIT cycles): Zlowout, Read, MDRin high every cycle; PCin high in the first cycle only; go to T2 after the last cycle.
REQ-020 T2 (1 cycle): MDRout and IRin high; go to T3.
REQ-021 T3 with OP_MFHI: HIout, Gra, Rin high; with OP_MFLO: LOout, Gra, Rin high; each then completes.
REQ-022 T3 with OP_MTHI: Gra, Rout, HIin high; with OP_MTLO: Gra, Rout, LOin high; each then completes.
REQ-023 T3 with OP_MUL or OP_DIV: Gra, Rout, Yin high; go to T4.
REQ-024 T4: Grb, Rout, mdiv_start high for exactly one cycle; go to MDWAIT.
REQ-025 MDWAIT: no strobes; go to T5 on mdiv_done=1; after MD_TIMEOUT cycles without it, set err=10 and go to HALT.
REQ-026 T5: Zlowout, LOin high; T6: Zhighout, HIin high; then complete.
REQ-027 T3 with OP_HALT: go to HALT with err unchanged.
REQ-028 T3 with any other opcode: set err=01 and go to HALT.
REQ-029 Completion: go to T0 if run=1, else to IDLE; run is sampled only in IDLE and at completion.
REQ-030 HALT: all strobes low, busy=0; exit only by reset.
REQ-031 mdiv_done outside MDWAIT SHALL be ignored.
REQ-032 mdiv_done in the same cycle that the timeout count expires SHALL count as success and go to T5.
REQ-033 At most one of HIout, LOout, Zhighout, Zlowout, MDRout, PCout, Rout SHALL be high in any cycle.
REQ-034 Wait counters SHALL be sized by $clog2 of their limits and SHALL clear on every state entry.
REQ-035 Latencies, clear release to first T0 with run=1: 1 cycle; MFHI/MFLO/MTHI/MTLO: 4+MEM_WAIT cycles each; MUL/DIV: 7+MEM_WAIT+(MDWAIT cycles).

Reset
REQ-036 clear=0 at a rising edge SHALL force IDLE, all outputs to 0, err=00, and counters to 0, including mid-instruction.
REQ-037 Reset SHALL take priority over every transition and over mdiv_done.

Verification
REQ-038 Reset release, run=1, ir_op=OP_MFHI, MEM_WAIT=1 -> T0,T1,T1,T2,T3 then T0; HIout, Gra, Rin high only in cycle 5.
REQ-039 Back-to-back OP_MTLO then OP_MFLO with run held 1 -> Rout+LOin in cycle 5 and LOout+Rin in cycle 10; no idle gap between instructions.
REQ-040 OP_MUL, mdiv_done pulsed on the 3rd MDWAIT cycle -> mdiv_start exactly one cycle; LOin then HIin on consecutive cycles; busy drops only if run=0 at completion.
REQ-041 OP_DIV, MD_TIMEOUT=4, no mdiv_done -> err=10 after 4 MDWAIT cycles; HALT; busy=0; strobes stay 0 until clear.
REQ-042 ir_op=5'h03 -> err=01, HALT; then clear=0 for one cycle -> IDLE, err=00.
REQ-043 clear=0 asserted in MDWAIT together with mdiv_done=1 -> IDLE next cycle; no LOin or HIin issued.
